// File: rtl/spad_gate_seq.sv
// rtl/spad_gate_seq.sv - SPAD quench/hold-off/reset/dead-time sequencer with status LEDs and event counter
module spad_gate_seq #(
  parameter int CW       = 16,
  parameter int T_QUENCH = 4,
  parameter int T_HOLD   = 8,
  parameter int T_RESET  = 4,
  parameter int T_DEAD   = 2,
  parameter int PWM_DIV  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          det_in,
  input  logic          force_rst,
  output logic          quench_en_n,
  output logic          quench_pwm,
  output logic          rst_en,
  output logic          rst_pwm,
  output logic          busy,
  output logic [3:0]    led,
  output logic [CW-1:0] event_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMED  = 3'd1;
  localparam logic [2:0] S_QUENCH = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_RESET  = 3'd4;
  localparam logic [2:0] S_DEAD   = 3'd5;

  localparam int TMAX_QH = (T_QUENCH > T_HOLD) ? T_QUENCH : T_HOLD;
  localparam int TMAX_RD = (T_RESET > T_DEAD) ? T_RESET : T_DEAD;
  localparam int TMAX    = (TMAX_QH > TMAX_RD) ? TMAX_QH : TMAX_RD;
  localparam int TW      = $clog2(TMAX + 1);
  localparam int DW      = $clog2(PWM_DIV + 1);

  localparam logic [TW-1:0] LD_QUENCH = TW'(T_QUENCH - 1);
  localparam logic [TW-1:0] LD_HOLD   = TW'(T_HOLD - 1);
  localparam logic [TW-1:0] LD_RESET  = TW'(T_RESET - 1);
  localparam logic [TW-1:0] LD_DEAD   = TW'(T_DEAD - 1);
  localparam logic [DW-1:0] LD_DIV    = DW'(PWM_DIV - 1);

  logic          s1_q, s2_q, s3_q;
  logic          det_rise;
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [DW-1:0] div_q, div_d;
  logic          car_q, car_d;
  logic          accept;
  logic          pwm_start;
  logic          quench_en_n_q, quench_pwm_q, rst_en_q, rst_pwm_q, busy_q;
  logic [3:0]    led_q;
  logic [CW-1:0] cnt_q, cnt_d;

  assign det_rise = s2_q & ~s3_q;

  // Timed states hold for tmr+1 clocks; idle states only react to requests.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_ARMED;
        end else if (force_rst) begin
          state_d = S_RESET;
          tmr_d   = LD_RESET;
        end
      end
      S_ARMED: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (force_rst) begin
          state_d = S_RESET;
          tmr_d   = LD_RESET;
        end else if (det_rise) begin
          state_d = S_QUENCH;
          tmr_d   = LD_QUENCH;
          accept  = 1'b1;
        end
      end
      S_QUENCH: begin
        if (tmr_q == '0) begin
          state_d = S_HOLD;
          tmr_d   = LD_HOLD;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_HOLD: begin
        if (tmr_q == '0) begin
          state_d = S_RESET;
          tmr_d   = LD_RESET;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_RESET: begin
        if (tmr_q == '0) begin
          state_d = S_DEAD;
          tmr_d   = LD_DEAD;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_DEAD: begin
        if (tmr_q == '0) begin
          state_d = enable ? S_ARMED : S_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // Carrier phase restarts high whenever a pulsed state is entered.
  always_comb begin
    pwm_start = (state_d != state_q) && ((state_d == S_QUENCH) || (state_d == S_RESET));
    car_d     = car_q;
    div_d     = div_q;
    if (pwm_start) begin
      car_d = 1'b1;
      div_d = LD_DIV;
    end else if (div_q == '0) begin
      car_d = ~car_q;
      div_d = LD_DIV;
    end else begin
      div_d = div_q - DW'(1);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      state_q       <= S_IDLE;
      tmr_q         <= '0;
      div_q         <= '0;
      car_q         <= 1'b0;
      quench_en_n_q <= 1'b1;
      quench_pwm_q  <= 1'b0;
      rst_en_q      <= 1'b0;
      rst_pwm_q     <= 1'b0;
      busy_q        <= 1'b0;
      led_q         <= 4'b0000;
      cnt_q         <= '0;
    end else begin
      s1_q          <= det_in;
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      div_q         <= div_d;
      car_q         <= car_d;
      quench_en_n_q <= ~((state_d == S_QUENCH) || (state_d == S_HOLD));
      quench_pwm_q  <= (state_d == S_QUENCH) & car_d;
      rst_en_q      <= (state_d == S_RESET);
      rst_pwm_q     <= (state_d == S_RESET) & car_d;
      busy_q        <= (state_d == S_QUENCH) || (state_d == S_HOLD) ||
                       (state_d == S_RESET) || (state_d == S_DEAD);
      led_q[0]      <= (state_d == S_ARMED);
      led_q[1]      <= (state_d == S_QUENCH) || (state_d == S_HOLD);
      led_q[2]      <= (state_d == S_RESET);
      led_q[3]      <= led_q[3] ^ accept;
      cnt_q         <= cnt_d;
    end
  end

  assign quench_en_n = quench_en_n_q;
  assign quench_pwm  = quench_pwm_q;
  assign rst_en      = rst_en_q;
  assign rst_pwm     = rst_pwm_q;
  assign busy        = busy_q;
  assign led         = led_q;
  assign event_cnt   = cnt_q;

endmodule

// File: tb/tb_spad_gate_seq.sv
// tb/tb_spad_gate_seq.sv - directed self-checking bench for spad_gate_seq
module tb_spad_gate_seq;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          det_in;
  logic          force_rst;
  logic          quench_en_n;
  logic          quench_pwm;
  logic          rst_en;
  logic          rst_pwm;
  logic          busy;
  logic [3:0]    led;
  logic [CW-1:0] event_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spad_gate_seq #(.CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .det_in      (det_in),
    .force_rst   (force_rst),
    .quench_en_n (quench_en_n),
    .quench_pwm  (quench_pwm),
    .rst_en      (rst_en),
    .rst_pwm     (rst_pwm),
    .busy        (busy),
    .led         (led),
    .event_cnt   (event_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {quench_en_n, quench_pwm, rst_en, rst_pwm, busy, led[2], led[1]}
  function automatic logic [6:0] obs_vec();
    return {quench_en_n, quench_pwm, rst_en, rst_pwm, busy, led[2], led[1]};
  endfunction

  // Detection sequence: QUENCH t3..6, HOLD t7..14, RESET t15..18, DEAD t19..20
  function automatic logic [6:0] exp_det(input int t);
    logic qn, qp, re, rp, bz;
    qn = !(t >= 3 && t <= 14);
    qp = (t == 3) || (t == 4);
    re = (t >= 15) && (t <= 18);
    rp = (t == 15) || (t == 16);
    bz = (t >= 3) && (t <= 20);
    return {qn, qp, re, rp, bz, re, !qn};
  endfunction

  // Forced reset: RESET t1..4, DEAD t5..6
  function automatic logic [6:0] exp_frc(input int t);
    logic re, rp, bz;
    re = (t <= 4);
    rp = (t <= 2);
    bz = (t <= 6);
    return {1'b1, 1'b0, re, rp, bz, re, 1'b0};
  endfunction

  task automatic run_det(input string tag, input int second_at, input int drop_at,
                         input logic [CW-1:0] exp_cnt, input logic [3:0] exp_led);
    det_in = 1'b1;
    for (int t = 1; t <= 21; t++) begin
      tick();
      check($sformatf("%s_t%0d", tag, t), 32'(obs_vec()), 32'(exp_det(t)));
      if (t == 3) det_in = 1'b0;
      if (second_at != 0 && t == second_at) det_in = 1'b1;
      if (second_at != 0 && t == second_at + 3) det_in = 1'b0;
      if (t == drop_at) enable = 1'b0;
    end
    check({tag, "_cnt"}, 32'(event_cnt), 32'(exp_cnt));
    check({tag, "_led"}, 32'(led), 32'(exp_led));
  endtask

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    det_in    = 1'b0;
    force_rst = 1'b0;

    // Reset with det_in toggling
    tick();
    det_in = 1'b1;
    tick();
    det_in = 1'b0;
    check("rst_vec", 32'(obs_vec()), 32'(7'b1000000));
    check("rst_led", 32'(led), 32'h0);
    check("rst_cnt", 32'(event_cnt), 32'h0);
    rst_n  = 1'b1;
    enable = 1'b1;
    tick();
    check("armed_led", 32'(led), 32'b0001);
    check("armed_busy", 32'(busy), 32'h0);

    run_det("single", 0, 0, 4'd1, 4'b1001);
    run_det("busy_ign", 11, 0, 4'd2, 4'b0001);
    run_det("en_drop", 0, 9, 4'd3, 4'b1000);

    // Detection while IDLE is ignored
    det_in = 1'b1;
    repeat (3) tick();
    det_in = 1'b0;
    repeat (4) tick();
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_cnt", 32'(event_cnt), 32'd3);
    enable = 1'b1;
    tick();
    check("rearm_led", 32'(led), 32'b1001);

    // Manual reset from ARMED
    force_rst = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      force_rst = 1'b0;
      check($sformatf("frc_t%0d", t), 32'(obs_vec()), 32'(exp_frc(t)));
    end
    check("frc_cnt", 32'(event_cnt), 32'd3);
    check("frc_led", 32'(led), 32'b1001);

    // force_rst and det_rise coincide: reset wins, no count
    det_in = 1'b1;
    tick();
    tick();
    force_rst = 1'b1;
    tick();
    force_rst = 1'b0;
    check("sim_vec", 32'(obs_vec()), 32'(exp_frc(1)));
    det_in = 1'b0;
    repeat (6) tick();
    check("sim_cnt", 32'(event_cnt), 32'd3);
    check("sim_led", 32'(led), 32'b1001);

    // Saturation at 2^CW-1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) begin
      det_in = 1'b1;
      repeat (3) tick();
      det_in = 1'b0;
      repeat (20) tick();
      if (i == 14) check("cnt15", 32'(event_cnt), 32'd15);
    end
    check("sat_cnt", 32'(event_cnt), 32'd15);
    check("sat_led", 32'(led), 32'b1001);

    // Reset in the middle of QUENCH
    det_in = 1'b1;
    repeat (3) tick();
    det_in = 1'b0;
    tick();
    check("midq_qn", 32'(quench_en_n), 32'h0);
    rst_n = 1'b0;
    tick();
    check("midq_vec", 32'(obs_vec()), 32'(7'b1000000));
    check("midq_led", 32'(led), 32'h0);
    check("midq_cnt", 32'(event_cnt), 32'h0);
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
